// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the ALU, LSU and MDU.
//
// Round-robin arbitration with one valid/ready handshake per source. The winner of each
// cycle is registered onto the write-back port one cycle after acceptance.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   {alu,lsu,mdu}_valid       source has a result pending
//   {alu,lsu,mdu}_ready       source result accepted this cycle (combinational)
//   {alu,lsu,mdu}_rd          destination register of the pending result
//   {alu,lsu,mdu}_data        pending result value
//   wb_en, wb_reg, wb_val     registered register-file write port
//   wb_src                    source of current write: 0=ALU, 1=LSU, 2=MDU, 3=none
//   busy                      any valid pending or a write being presented
//
// Optional feature (macro RF_WB_STALL_CNT_EN): adds saturating 32-bit per-source stall
// counters {alu,lsu,mdu}_stall_cnt, counting cycles with valid=1 and ready=0.

module rf_wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RW   = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [RW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,

    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [RW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,

    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [RW-1:0]   mdu_rd,
    input  logic [XLEN-1:0] mdu_data,

`ifdef RF_WB_STALL_CNT_EN
    output logic [31:0]     alu_stall_cnt,
    output logic [31:0]     lsu_stall_cnt,
    output logic [31:0]     mdu_stall_cnt,
`endif

    output logic            wb_en,
    output logic [RW-1:0]   wb_reg,
    output logic [XLEN-1:0] wb_val,
    output logic [1:0]      wb_src,
    output logic            busy
);

    localparam logic [1:0] SrcAlu  = 2'd0;
    localparam logic [1:0] SrcLsu  = 2'd1;
    localparam logic [1:0] SrcMdu  = 2'd2;
    localparam logic [1:0] SrcNone = 2'd3;

    logic [1:0]      ptr_q, ptr_d;
    logic            wb_en_q, wb_en_d;
    logic [RW-1:0]   wb_reg_q, wb_reg_d;
    logic [XLEN-1:0] wb_val_q, wb_val_d;
    logic [1:0]      wb_src_q, wb_src_d;

    logic [2:0]      valid_vec;
    logic [1:0]      ptr_eff;
    logic [1:0]      grant_src;
    logic [2:0]      grant_oh;
    logic            xfer;
    logic [RW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    assign valid_vec = {mdu_valid, lsu_valid, alu_valid};
    // Encoding 3 cannot be reached, but recover to ALU if it ever appears.
    assign ptr_eff   = (ptr_q == SrcNone) ? SrcAlu : ptr_q;

    // Rotating priority search starting at ptr_eff.
    always_comb begin
        grant_src = SrcNone;
        case (ptr_eff)
            SrcLsu: begin
                if      (valid_vec[1]) grant_src = SrcLsu;
                else if (valid_vec[2]) grant_src = SrcMdu;
                else if (valid_vec[0]) grant_src = SrcAlu;
            end
            SrcMdu: begin
                if      (valid_vec[2]) grant_src = SrcMdu;
                else if (valid_vec[0]) grant_src = SrcAlu;
                else if (valid_vec[1]) grant_src = SrcLsu;
            end
            default: begin
                if      (valid_vec[0]) grant_src = SrcAlu;
                else if (valid_vec[1]) grant_src = SrcLsu;
                else if (valid_vec[2]) grant_src = SrcMdu;
            end
        endcase
    end

    // No grants during reset, so nothing is accepted that reset would then drop silently.
    always_comb begin
        grant_oh = 3'b000;
        if (!rst) begin
            case (grant_src)
                SrcAlu:  grant_oh = 3'b001;
                SrcLsu:  grant_oh = 3'b010;
                SrcMdu:  grant_oh = 3'b100;
                default: grant_oh = 3'b000;
            endcase
        end
    end

    assign alu_ready = grant_oh[0];
    assign lsu_ready = grant_oh[1];
    assign mdu_ready = grant_oh[2];
    assign xfer      = |grant_oh;

    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        case (grant_src)
            SrcLsu: begin
                sel_rd   = lsu_rd;
                sel_data = lsu_data;
            end
            SrcMdu: begin
                sel_rd   = mdu_rd;
                sel_data = mdu_data;
            end
            default: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        wb_en_d  = 1'b0;
        wb_reg_d = wb_reg_q;
        wb_val_d = wb_val_q;
        wb_src_d = SrcNone;
        if (xfer) begin
            // x0 writes are consumed but never reach the register file.
            wb_en_d  = (sel_rd != '0);
            wb_reg_d = sel_rd;
            wb_val_d = sel_data;
            wb_src_d = grant_src;
            ptr_d    = (grant_src == SrcMdu) ? SrcAlu : grant_src + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= SrcAlu;
            wb_en_q  <= 1'b0;
            wb_reg_q <= '0;
            wb_val_q <= '0;
            wb_src_q <= SrcNone;
        end else begin
            ptr_q    <= ptr_d;
            wb_en_q  <= wb_en_d;
            wb_reg_q <= wb_reg_d;
            wb_val_q <= wb_val_d;
            wb_src_q <= wb_src_d;
        end
    end

    assign wb_en  = wb_en_q;
    assign wb_reg = wb_reg_q;
    assign wb_val = wb_val_q;
    assign wb_src = wb_src_q;
    assign busy   = (|valid_vec) | wb_en_q;

`ifdef RF_WB_STALL_CNT_EN
    logic [31:0] alu_stall_q, alu_stall_d;
    logic [31:0] lsu_stall_q, lsu_stall_d;
    logic [31:0] mdu_stall_q, mdu_stall_d;

    // Saturating counters of cycles spent waiting for a grant.
    always_comb begin
        alu_stall_d = alu_stall_q;
        lsu_stall_d = lsu_stall_q;
        mdu_stall_d = mdu_stall_q;
        if (alu_valid && !alu_ready && (alu_stall_q != 32'hFFFF_FFFF)) begin
            alu_stall_d = alu_stall_q + 32'd1;
        end
        if (lsu_valid && !lsu_ready && (lsu_stall_q != 32'hFFFF_FFFF)) begin
            lsu_stall_d = lsu_stall_q + 32'd1;
        end
        if (mdu_valid && !mdu_ready && (mdu_stall_q != 32'hFFFF_FFFF)) begin
            mdu_stall_d = mdu_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_stall_q <= '0;
            lsu_stall_q <= '0;
            mdu_stall_q <= '0;
        end else begin
            alu_stall_q <= alu_stall_d;
            lsu_stall_q <= lsu_stall_d;
            mdu_stall_q <= mdu_stall_d;
        end
    end

    assign alu_stall_cnt = alu_stall_q;
    assign lsu_stall_cnt = lsu_stall_q;
    assign mdu_stall_cnt = mdu_stall_q;
`endif

endmodule
